gs_divisor_prenorm: RTL

//  Upstream operand stage for the 8-bit Goldschmidt divider (x/y -> Q).
//  - Accepts one dividend/divisor pair per handshake.
//  - Left-shifts the divisor, one bit per cycle, until its MSB is set (y_norm in [0.5,1)).
//  - Presents x, y_norm, the shift count and a divide-by-zero flag to the divider.
//  - Downstream rescales the quotient by 2^shift.

---
 rtl/gs_divisor_prenorm_if.sv | 28 ++
 rtl/gs_divisor_prenorm.sv | 79 +++++++
 2 files changed

// File: rtl/gs_divisor_prenorm_if.sv
// Operand handshake bundle between the Goldschmidt divisor pre-normaliser,
// its producer, and the divider that consumes the normalised pair.
interface gs_divisor_prenorm_if #(
    parameter int W = 8
);
    localparam int SW = $clog2(W);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic [W-1:0]  in_y;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_x;
    logic [W-1:0]  out_y;
    logic [SW-1:0] out_shift;
    logic          out_dz;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_shift, out_dz
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_x, out_y, out_shift, out_dz
    );
endinterface

// File: rtl/gs_divisor_prenorm.sv
// Divisor pre-normaliser: shifts y left one bit per cycle until its MSB is set,
// reporting the shift count and a divide-by-zero flag alongside the dividend.
module gs_divisor_prenorm #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    gs_divisor_prenorm_if.slave bus
);
    localparam int SW = $clog2(W);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_r;
    logic [W-1:0]  x_r;
    logic [W-1:0]  y_r;
    logic [SW-1:0] cnt_r;
    logic          dz_r;
    logic          valid_r;

    // Outputs come straight from the working registers, so nothing downstream
    // sees a combinational path from out_ready.
    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = valid_r;
    assign bus.out_x     = x_r;
    assign bus.out_y     = y_r;
    assign bus.out_shift = cnt_r;
    assign bus.out_dz    = dz_r;

    // Operand capture, normalisation shifting and result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            x_r     <= '0;
            y_r     <= '0;
            cnt_r   <= '0;
            dz_r    <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_r     <= bus.in_x;
                        y_r     <= bus.in_y;
                        cnt_r   <= '0;
                        dz_r    <= (bus.in_y == '0);
                        valid_r <= 1'b0;
                        state_r <= (bus.in_y == '0) ? DONE : NORM;
                    end
                end
                NORM: begin
                    if (y_r[W-1]) begin
                        state_r <= DONE;
                        valid_r <= 1'b1;
                    end else begin
                        y_r   <= {y_r[W-2:0], 1'b0};
                        cnt_r <= cnt_r + SW'(1);
                    end
                end
                DONE: begin
                    // A zero divisor enters DONE straight from IDLE; valid rises
                    // one edge later so its latency matches an aligned divisor.
                    if (valid_r && bus.out_ready) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
